// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and the round-robin pick function
// for the mux4_rr_arbiter slice.
package mux_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set request at or after ptr, scanning circularly.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p = '0;
        // Walk from the farthest candidate back to ptr so the nearest one wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// Combinational W-wide 4:1 selector; lane i = lanes[i*W +: W].
module mux4_sel
    import mux_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [NREQ*W-1:0] lanes,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      out
);

    assign out = lanes[sel*W +: W];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a 4:1 data mux, holding each
// grant until a beat with last; MUX_ARB_TIMEOUT_EN adds a stall-timeout release.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [NREQ*DATA_W-1:0] data_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [NREQ-1:0]        gnt,
    output logic [SEL_W-1:0]       sel,
    output logic                   busy
`ifdef MUX_ARB_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic             req_sel;
    logic             fire;
    logic             release_now;
    logic             expire;
    logic [SEL_W-1:0] pick_base;
    pick_t            pick;

    mux4_sel #(.W(DATA_W)) u_data_sel (
        .lanes (data_in),
        .sel   (sel_q),
        .out   (out_data)
    );

    mux4_sel #(.W(1)) u_valid_sel (
        .lanes (req),
        .sel   (sel_q),
        .out   (req_sel)
    );

    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req_sel;
    assign fire      = out_valid & out_ready;
    assign gnt       = gnt_q;
    assign sel       = sel_q;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic             timeout_q, timeout_d;

    // The edge that ends the TIMEOUT_CYC-th consecutive stalled cycle releases.
    assign expire = busy && !fire && (stall_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        stall_d   = stall_q + CNT_W'(1);
        timeout_d = expire;
        if (!busy || fire || expire) begin
            stall_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire = 1'b0;
`endif

    assign release_now = (fire && last[sel_q]) || expire;
    // On release the search starts just past the finishing requester.
    assign pick_base   = busy ? sel_q + SEL_W'(1) : ptr_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        pick    = rr_pick(req, pick_base);

        if (!busy || release_now) begin
            if (busy) begin
                ptr_d = pick_base;
            end
            if (pick.found) begin
                state_d = GRANT;
                sel_d   = pick.idx;
                gnt_d   = NREQ'(1) << pick.idx;
            end else begin
                state_d = IDLE;
                sel_d   = '0;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboarded random and directed bench for mux4_rr_arbiter against a
// transaction-level round-robin model.
module tb_mux4_rr_arbiter;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    last;
    logic [4*DW-1:0] data_in;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          busy;
`ifdef MUX_ARB_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy)
`ifdef MUX_ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]    gnt;
        int            sel;
        logic          valid;
        logic [DW-1:0] data;
        logic          to;
    } cyc_t;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
    } beat_t;

    cyc_t  cyc_q[$];
    beat_t beat_q[$];

    // Reference model: owner (-1 = nobody), rotating start point, stall count.
    int owner      = -1;
    int ptr        = 0;
    int stall      = 0;
    bit to_pending = 1'b0;

    function automatic int scan(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [4*DW-1:0] rnd_lanes();
        logic [4*DW-1:0] d;
        for (int i = 0; i < 4; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // One clock of stimulus; the model predicts this cycle's outputs, then advances.
    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                         input logic [4*DW-1:0] d);
        cyc_t  c;
        beat_t b;
        bit    beat;
        bit    rel;
        @(posedge clk);
        #1;
        req       = r;
        last      = l;
        out_ready = rdy;
        data_in   = d;
        c.gnt   = (owner < 0) ? 4'b0000 : 4'(1 << owner);
        c.sel   = (owner < 0) ? 0 : owner;
        c.valid = (owner >= 0) && r[owner];
        c.data  = d[c.sel*DW +: DW];
        c.to    = to_pending;
        to_pending = 1'b0;
        beat = c.valid && rdy;
        if (beat) begin
            b.lane = owner;
            b.data = c.data;
            beat_q.push_back(b);
        end
        cyc_q.push_back(c);
        if (owner < 0) begin
            owner = scan(r, ptr);
        end else begin
            rel = beat && l[owner];
`ifdef MUX_ARB_TIMEOUT_EN
            if (beat) begin
                stall = 0;
            end else begin
                stall++;
                if (stall == TO) begin
                    rel        = 1'b1;
                    to_pending = 1'b1;
                    stall      = 0;
                end
            end
`endif
            if (rel) begin
                ptr   = (owner + 1) % 4;
                owner = scan(r, ptr);
            end
        end
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset(input string nm);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check({nm, "_gnt"}, gnt, 4'b0000);
        check({nm, "_sel"}, sel, 2'd0);
        check({nm, "_busy"}, busy, 1'b0);
        check({nm, "_out_valid"}, out_valid, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
        check({nm, "_timeout"}, timeout, 1'b0);
`endif
        req        = '0;
        last       = '0;
        out_ready  = 1'b0;
        owner      = -1;
        ptr        = 0;
        stall      = 0;
        to_pending = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic expect_gnt(input string nm, input logic [3:0] e);
        @(negedge clk);
        #1;
        check(nm, gnt, e);
    endtask

    // Monitor: per-cycle outputs against the model, beats against the scoreboard.
    always @(negedge clk) begin : monitor
        cyc_t  c;
        beat_t b;
        if (rst_n && cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            check("gnt", gnt, c.gnt);
            check("sel", sel, c.sel);
            check("busy", busy, |c.gnt);
            check("out_valid", out_valid, c.valid);
            check("out_data", out_data, c.data);
`ifdef MUX_ARB_TIMEOUT_EN
            check("timeout", timeout, c.to);
`endif
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat_unexpected: got lane %0d data %0h, expected no beat", sel, out_data);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_lane", sel, b.lane);
                    check("beat_data", out_data, b.data);
                end
            end
        end
    end

    logic [4*DW-1:0] fixed_d;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        last      = '0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        do_reset("por");

        // Reset mid-transfer, then a fresh grant to requester 0.
        cycle(4'b0100, 4'b0000, 1'b1, rnd_lanes());
        cycle(4'b0100, 4'b0000, 1'b1, rnd_lanes());
        do_reset("mid_reset");
        cycle(4'b0001, 4'b0001, 1'b1, rnd_lanes());
        cycle(4'b0001, 4'b0001, 1'b1, rnd_lanes());
        expect_gnt("after_reset_gnt", 4'b0001);

        // Single requester, 3 beats; last beat with req 0101 wraps the grant to 0.
        do_reset("t2");
        cycle(4'b0100, 4'b0000, 1'b1, rnd_lanes());
        expect_gnt("t2_gnt_latency", 4'b0000);
        cycle(4'b0100, 4'b0000, 1'b1, rnd_lanes());
        expect_gnt("t2_gnt", 4'b0100);
        cycle(4'b0100, 4'b0000, 1'b1, rnd_lanes());
        cycle(4'b0101, 4'b0100, 1'b1, rnd_lanes());
        cycle(4'b0101, 4'b0000, 1'b1, rnd_lanes());
        expect_gnt("wrap_gnt", 4'b0001);

        // All four requesting, single-beat transfers: 0,1,2,3,0 back to back.
        do_reset("t3");
        for (int k = 0; k < 6; k++) begin
            cycle(4'b1111, 4'b1111, 1'b1, rnd_lanes());
            expect_gnt($sformatf("rr_gnt_%0d", k), (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4)));
        end

        // Backpressure on requester 1 with others pending.
        do_reset("t4");
        fixed_d = rnd_lanes();
        cycle(4'b0010, 4'b0000, 1'b1, fixed_d);
        for (int k = 0; k < 5; k++) cycle(4'b1111, 4'b0010, 1'b0, fixed_d);
        expect_gnt("bp_hold_gnt", 4'b0010);
        cycle(4'b1111, 4'b0010, 1'b1, fixed_d);
        cycle(4'b1111, 4'b0000, 1'b0, fixed_d);
        expect_gnt("bp_next_gnt", 4'b0100);

`ifdef MUX_ARB_TIMEOUT_EN
        // Requester 3 goes quiet while granted; requester 0 takes over on timeout.
        do_reset("t6");
        cycle(4'b1000, 4'b0000, 1'b1, rnd_lanes());
        for (int k = 0; k < TO; k++) cycle(4'b0001, 4'b0000, 1'b1, rnd_lanes());
        expect_gnt("to_hold_gnt", 4'b1000);
        cycle(4'b0001, 4'b0000, 1'b0, rnd_lanes());
        expect_gnt("to_new_gnt", 4'b0001);
        check("to_pulse", timeout, 1'b1);
`endif

        // Random traffic.
        do_reset("rand");
        for (int k = 0; k < 2000; k++) begin
            cycle(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                  $urandom_range(0, 3) != 0, rnd_lanes());
        end

        @(negedge clk);
        #1;
        check("cyc_q_drained", cyc_q.size(), 0);
        check("beat_q_drained", beat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
